// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pattern-mode encoding, width helper and standard 640x480@60 timing
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_EXT    = 2'd3
  } mode_e;

  localparam int STD_PIX_DIV = 2;
  localparam int STD_H_ACT   = 640;
  localparam int STD_H_FP    = 16;
  localparam int STD_H_SYNC  = 96;
  localparam int STD_H_BP    = 48;
  localparam int STD_V_ACT   = 480;
  localparam int STD_V_FP    = 10;
  localparam int STD_V_SYNC  = 2;
  localparam int STD_V_BP    = 33;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - pixel divider, raster counters and raw act/sync decode
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int PIX_DIV = STD_PIX_DIV,
  parameter int H_ACT   = STD_H_ACT,
  parameter int H_FP    = STD_H_FP,
  parameter int H_SYNC  = STD_H_SYNC,
  parameter int H_BP    = STD_H_BP,
  parameter int V_ACT   = STD_V_ACT,
  parameter int V_FP    = STD_V_FP,
  parameter int V_SYNC  = STD_V_SYNC,
  parameter int V_BP    = STD_V_BP,
  localparam int XW = clog2(H_ACT + H_FP + H_SYNC + H_BP),
  localparam int YW = clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pixCe,
  output logic [XW-1:0] xPos,
  output logic [YW-1:0] yPos,
  output logic          act,
  output logic          hsRaw,
  output logic          vsRaw
);

  localparam int DW = (PIX_DIV > 1) ? clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACT);
  localparam logic [XW-1:0] HS_START = XW'(H_ACT + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACT + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACT);
  localparam logic [YW-1:0] VS_START = YW'(V_ACT + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACT + V_FP + V_SYNC);

  logic [DW-1:0] div;

  // With PIX_DIV=1 DIV_LAST is zero, so div never leaves 0 and pixCe stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign pixCe = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xPos <= '0;
      yPos <= '0;
    end else if (pixCe) begin
      if (xPos == X_LAST) begin
        xPos <= '0;
        yPos <= (yPos == Y_LAST) ? '0 : yPos + YW'(1);
      end else begin
        xPos <= xPos + XW'(1);
      end
    end
  end

  assign act   = (xPos < X_ACT) && (yPos < Y_ACT);
  assign hsRaw = (xPos >= HS_START) && (xPos < HS_END);
  assign vsRaw = (yPos >= VS_START) && (yPos < VS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing top: per-frame mode latch, test patterns, registered pixel outputs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV    = STD_PIX_DIV,
  parameter int H_ACT      = STD_H_ACT,
  parameter int H_FP       = STD_H_FP,
  parameter int H_SYNC     = STD_H_SYNC,
  parameter int H_BP       = STD_H_BP,
  parameter int V_ACT      = STD_V_ACT,
  parameter int V_FP       = STD_V_FP,
  parameter int V_SYNC     = STD_V_SYNC,
  parameter int V_BP       = STD_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int RW         = 3,
  parameter int GW         = 3,
  parameter int BW         = 2,
  parameter int CHECK_LOG2 = 3,
  localparam int XW = clog2(H_ACT + H_FP + H_SYNC + H_BP),
  localparam int YW = clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [RW+GW+BW-1:0] ext_rgb,
  output logic                pix_ce,
  output logic [XW-1:0]       x_pos,
  output logic [YW-1:0]       y_pos,
  output logic [RW-1:0]       red,
  output logic [GW-1:0]       green,
  output logic [BW-1:0]       blue,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic                frame_start
);

  localparam int CW = RW + GW + BW;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [XW-1:0] BAR_LAST = XW'(H_ACT / 8 - 1);
  localparam logic [XW-1:0] X_B1     = XW'(10);
  localparam logic [XW-1:0] X_B2     = XW'(H_ACT - 11);
  localparam logic [XW-1:0] X_B3     = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_B1     = YW'(10);
  localparam logic [YW-1:0] Y_B2     = YW'(V_ACT - 11);
  localparam logic [YW-1:0] Y_B3     = YW'(V_ACT - 1);

  logic          pixCe;
  logic [XW-1:0] xCnt;
  logic [YW-1:0] yCnt;
  logic          act;
  logic          hsRaw;
  logic          vsRaw;

  vga_timing_core #(
    .PIX_DIV (PIX_DIV),
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .pixCe (pixCe),
    .xPos  (xCnt),
    .yPos  (yCnt),
    .act   (act),
    .hsRaw (hsRaw),
    .vsRaw (vsRaw)
  );

  assign pix_ce = pixCe;
  assign x_pos  = xCnt;
  assign y_pos  = yCnt;

  logic  origin;
  mode_e modeQ;
  mode_e modeEff;

  assign origin = (xCnt == '0) && (yCnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modeQ <= MODE_BORDER;
    end else if (pixCe && origin) begin
      modeQ <= mode_e'(mode);
    end
  end

  // Pixel (0,0) already belongs to the new frame, so it uses the mode being latched.
  assign modeEff = origin ? mode_e'(mode) : modeQ;

  logic [2:0]    barIdx;
  logic [XW-1:0] barPix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      barIdx <= '0;
      barPix <= '0;
    end else if (pixCe) begin
      if (xCnt == X_LAST) begin
        barIdx <= '0;
        barPix <= '0;
      end else if (barPix == BAR_LAST) begin
        barIdx <= barIdx + 3'd1;
        barPix <= '0;
      end else begin
        barPix <= barPix + XW'(1);
      end
    end
  end

  logic          onBorder;
  logic          checkOn;
  logic [CW-1:0] patRgb;

  assign onBorder = (xCnt == '0) || (xCnt == X_B1) || (xCnt == X_B2) || (xCnt == X_B3) ||
                    (yCnt == '0) || (yCnt == Y_B1) || (yCnt == Y_B2) || (yCnt == Y_B3);
  assign checkOn  = xCnt[CHECK_LOG2] ^ yCnt[CHECK_LOG2];

  always_comb begin
    patRgb = '0;
    case (modeEff)
      MODE_BORDER: patRgb = onBorder ? '1 : '0;
      MODE_CHECK:  patRgb = checkOn ? '1 : '0;
      MODE_BARS:   patRgb = {{RW{barIdx[2]}}, {GW{barIdx[1]}}, {BW{barIdx[0]}}};
      MODE_EXT:    patRgb = ext_rgb;
      default:     patRgb = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      de          <= 1'b0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      frame_start <= 1'b0;
    end else if (pixCe) begin
      red         <= act ? patRgb[CW-1 -: RW] : '0;
      green       <= act ? patRgb[BW +: GW]   : '0;
      blue        <= act ? patRgb[BW-1:0]     : '0;
      de          <= act;
      hsync       <= hsRaw ? HS_POL : !HS_POL;
      vsync       <= vsRaw ? VS_POL : !VS_POL;
      frame_start <= origin;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of a small-raster VGA generator at two divider/polarity settings
module tb_vga_timing_gen;

  localparam int HT   = 22;
  localparam int VT   = 14;
  localparam int NPIX = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] modeA, modeB;
  logic [7:0] extA, extB;

  logic       pixA, hsA, vsA, deA, fsA;
  logic [4:0] xA;
  logic [3:0] yA;
  logic [2:0] rA, gA;
  logic [1:0] bA;
  logic       pixB, hsB, vsB, deB, fsB;
  logic [4:0] xB;
  logic [3:0] yB;
  logic [2:0] rB, gB;
  logic [1:0] bB;
  logic [7:0] rgbA, rgbB;

  assign rgbA = {rA, gA, bA};
  assign rgbB = {rB, gB, bB};

  always #10 clk = ~clk;

  vga_timing_gen #(
    .PIX_DIV(2), .H_ACT(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .RW(3), .GW(3), .BW(2), .CHECK_LOG2(2)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .mode(modeA), .ext_rgb(extA), .pix_ce(pixA),
    .x_pos(xA), .y_pos(yA), .red(rA), .green(gA), .blue(bA),
    .hsync(hsA), .vsync(vsA), .de(deA), .frame_start(fsA)
  );

  vga_timing_gen #(
    .PIX_DIV(1), .H_ACT(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .RW(3), .GW(3), .BW(2), .CHECK_LOG2(2)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .mode(modeB), .ext_rgb(extB), .pix_ce(pixB),
    .x_pos(xB), .y_pos(yB), .red(rB), .green(gB), .blue(bB),
    .hsync(hsB), .vsync(vsB), .de(deB), .frame_start(fsB)
  );

  int errors = 0;
  int checks = 0;
  int curIdx = 0;
  bit bDone  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance dutA's outputs by exactly one pixel, ending on a sample negedge.
  task automatic stepPix();
    int n;
    n = 0;
    while (!pixA && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("pix_ce_timeout", 32'd0, 32'd1);
    @(negedge clk);
    curIdx = (curIdx + 1) % NPIX;
  endtask

  task automatic seek(input int x, input int y);
    int target;
    int guard;
    target = y * HT + x;
    guard  = 0;
    while (curIdx != target && guard < 2 * NPIX) begin
      stepPix();
      guard++;
    end
  endtask

  // dutB: PIX_DIV=1, active-high syncs, checker mode; k-th negedge after release shows pixel k.
  initial begin
    @(posedge rst_n);
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clk);
      case (k)
        0: begin
          chk("B_pixce_const", pixB, 1);
          chk("B_fs_origin", fsB, 1);
          chk("B_rgb_0_0", rgbB, 8'h00);
          chk("B_xpos_ahead", xB, 1);
        end
        4:            chk("B_rgb_4_0", rgbB, 8'hFF);
        17:           chk("B_hs_17", hsB, 0);
        18:           chk("B_hs_18", hsB, 1);
        20: begin
          chk("B_rgb_blank_20", rgbB, 8'h00);
          chk("B_de_20", deB, 0);
        end
        4 * HT + 4:   chk("B_rgb_4_4", rgbB, 8'h00);
        10 * HT:      chk("B_vs_10", vsB, 1);
        12 * HT:      chk("B_vs_12", vsB, 0);
        default: ;
      endcase
    end
    bDone = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    modeA = 2'd0;
    modeB = 2'd1;
    extA  = 8'h00;
    extB  = 8'h00;
    repeat (10) @(negedge clk);

    chk("rst_rgb", rgbA, 8'h00);
    chk("rst_de", deA, 0);
    chk("rst_hs", hsA, 1);
    chk("rst_vs", vsA, 1);
    chk("rst_fs", fsA, 0);
    chk("rst_x", xA, 0);
    chk("rst_y", yA, 0);
    chk("rst_pixce", pixA, 0);
    chk("rst_B_hs", hsB, 0);
    chk("rst_B_vs", vsB, 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_pixce_clk1", pixA, 1);
    chk("rel_x_clk1", xA, 0);
    chk("rel_fs_clk1", fsA, 0);
    @(negedge clk);
    chk("rel_fs_clk2", fsA, 1);
    chk("rel_x_clk2", xA, 1);
    chk("rel_border_0_0", rgbA, 8'hFF);
    chk("rel_de_0_0", deA, 1);
    curIdx = 0;

    // Frame 0: border pattern and sync timing
    seek(17, 0);  chk("hs_17", hsA, 1); chk("de_17", deA, 0); chk("rgb_17", rgbA, 8'h00);
    seek(18, 0);  chk("hs_18", hsA, 0);
    seek(19, 0);  chk("hs_19", hsA, 0);
    seek(20, 0);  chk("hs_20", hsA, 1);
    seek(1, 1);   chk("border_1_1", rgbA, 8'h00);
    seek(10, 2);  chk("border_10_2", rgbA, 8'hFF);
    seek(5, 3);   chk("border_5_3", rgbA, 8'hFF);
    seek(3, 4);   chk("border_3_4", rgbA, 8'h00);
    modeA = 2'd1;
    seek(5, 4);   chk("border_persist_5_4", rgbA, 8'hFF);
    seek(3, 7);   chk("border_3_7", rgbA, 8'hFF);
    seek(21, 9);  chk("vs_9", vsA, 1);
    seek(0, 10);  chk("vs_10", vsA, 0); chk("de_10", deA, 0);
    seek(21, 11); chk("vs_11", vsA, 0);
    seek(0, 12);  chk("vs_12", vsA, 1);
    seek(21, 13); chk("fs_end", fsA, 0);

    // Frame 1: checker
    seek(0, 0);   chk("fs_f1", fsA, 1); chk("check_0_0", rgbA, 8'h00);
    seek(4, 1);   chk("check_4_1", rgbA, 8'hFF);
    seek(0, 4);   chk("check_0_4", rgbA, 8'hFF);
    seek(4, 4);   chk("check_4_4", rgbA, 8'h00);
    modeA = 2'd2;
    seek(2, 5);   chk("check_persist_2_5", rgbA, 8'hFF);

    // Frame 2: colour bars, two pixels per bar
    seek(0, 0);   chk("fs_f2", fsA, 1);
    seek(1, 0);   chk("bar0_x1", rgbA, 8'h00);
    seek(2, 0);   chk("bar1_x2", rgbA, 8'h03);
    seek(9, 0);   chk("bar4_x9", rgbA, 8'hE0);
    seek(13, 0);  chk("bar6_x13", rgbA, 8'hFC);
    seek(3, 1);   chk("bar1_line1", rgbA, 8'h03);
    seek(14, 3);  chk("bar7_x14", rgbA, 8'hFF);
    seek(15, 3);  chk("bar7_x15", rgbA, 8'hFF);
    modeA = 2'd3;
    extA  = 8'h5A;

    // Frame 3: external pixels, then a mid-frame reset
    seek(0, 0);   chk("ext_0_0", rgbA, 8'h5A); chk("fs_f3", fsA, 1);
    seek(19, 5);  chk("ext_hs_19_5", hsA, 0);
    seek(6, 6);   chk("ext_6_6", rgbA, 8'h5A);
    rst_n = 1'b0;
    #1;
    chk("arst_rgb", rgbA, 8'h00);
    chk("arst_de", deA, 0);
    chk("arst_hs", hsA, 1);
    chk("arst_vs", vsA, 1);
    chk("arst_x", xA, 0);
    chk("arst_y", yA, 0);
    extA = 8'hA5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rerel_fs", fsA, 1);
    chk("rerel_ext", rgbA, 8'hA5);
    chk("rerel_de", deA, 1);

    for (int i = 0; i < 1000 && !bDone; i++) @(negedge clk);
    chk("B_done", bDone, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
